// File: rtl/serial_full_sub.sv
// serial_full_sub: multi-cycle subtractor, diff = a - b - bin, DIGIT bits per clock, LSB digit first
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, a, b, bin  request and operands, captured when idle
//   busy, done        run in progress, one-cycle completion pulse
//   diff, barrow, ovf registered result, borrow-out, signed overflow
module serial_full_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             barrow,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_chk
    $error("serial_full_sub: DIGIT must divide WIDTH");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, res, res_nx;
  logic             am, bm, brw, last;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dd;
  logic [DIGIT:0]   bc;
  assign bc[0] = brw;
  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    assign dd[g]   = opa[g] ^ opb[g] ^ bc[g];
    assign bc[g+1] = (~opa[g] & opb[g]) | (~(opa[g] ^ opb[g]) & bc[g]);
  end
  // new digit enters at the top so the LSB digit ends up at bit 0 after N steps
  assign res_nx = WIDTH'({dd, res} >> DIGIT);
  assign last   = cnt == CW'(N - 1);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb state_nx = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  assign busy = state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      am     <= 1'b0;
      bm     <= 1'b0;
      brw    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      barrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        opa <= a;
        opb <= b;
        brw <= bin;
        am  <= a[WIDTH-1];
        bm  <= b[WIDTH-1];
        res <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        opa <= opa >> DIGIT;
        opb <= opb >> DIGIT;
        brw <= bc[DIGIT];
        res <= res_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          diff   <= res_nx;
          barrow <= bc[DIGIT];
          ovf    <= (am ^ bm) & (res_nx[WIDTH-1] ^ am);
          done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_full_sub.sv
// tb_serial_full_sub: scoreboard bench for serial_full_sub in three configurations
module tb_serial_full_sub;
  logic clk, rst;
  int   ecount = 0, n_cmp = 0, n_bad = 0;
  typedef struct {logic [7:0] d; logic bo; logic ov; int cyc;} exp_t;
  exp_t qx[$], qy[$], qz[$];

  logic       st_x, i_x, busy_x, done_x, bo_x, ov_x;
  logic [7:0] a_x, b_x, d_x;
  logic       st_y, i_y, busy_y, done_y, bo_y, ov_y;
  logic [7:0] a_y, b_y, d_y;
  logic       st_z, i_z, busy_z, done_z, bo_z, ov_z;
  logic [0:0] a_z, b_z, d_z;

  serial_full_sub #(.WIDTH(8), .DIGIT(1)) u_x (.clk(clk), .rst(rst), .start(st_x), .a(a_x), .b(b_x), .bin(i_x),
    .busy(busy_x), .done(done_x), .diff(d_x), .barrow(bo_x), .ovf(ov_x));
  serial_full_sub #(.WIDTH(8), .DIGIT(4)) u_y (.clk(clk), .rst(rst), .start(st_y), .a(a_y), .b(b_y), .bin(i_y),
    .busy(busy_y), .done(done_y), .diff(d_y), .barrow(bo_y), .ovf(ov_y));
  serial_full_sub #(.WIDTH(1), .DIGIT(1)) u_z (.clk(clk), .rst(rst), .start(st_z), .a(a_z), .b(b_z), .bin(i_z),
    .busy(busy_z), .done(done_z), .diff(d_z), .barrow(bo_z), .ovf(ov_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string nm, input exp_t e, input logic [7:0] d, input logic bo, input logic ov);
    n_cmp++;
    if (d !== e.d || bo !== e.bo || ov !== e.ov || ecount != e.cyc) begin
      n_bad++;
      $display("FAIL %s: got diff=%h barrow=%b ovf=%b at edge %0d, expected diff=%h barrow=%b ovf=%b at edge %0d",
               nm, d, bo, ov, ecount, e.d, e.bo, e.ov, e.cyc);
    end
  endtask

  task automatic expect_v(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: done with no pending expectation at edge %0d", nm, ecount);
  endtask

  always @(negedge clk) if (done_x) begin
    if (qx.size() == 0) unexpected("w8d1"); else chk("w8d1", qx.pop_front(), d_x, bo_x, ov_x);
  end
  always @(negedge clk) if (done_y) begin
    if (qy.size() == 0) unexpected("w8d4"); else chk("w8d4", qy.pop_front(), d_y, bo_y, ov_y);
  end
  always @(negedge clk) if (done_z) begin
    if (qz.size() == 0) unexpected("w1"); else chk("w1", qz.pop_front(), {7'b0, d_z}, bo_z, ov_z);
  end

  task automatic push(input int w, input exp_t e);
    case (w)
      0: qx.push_back(e);
      1: qy.push_back(e);
      default: qz.push_back(e);
    endcase
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (qx.size() == 0 && qy.size() == 0 && qz.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (qx.size() != 0 || qy.size() != 0 || qz.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: results still pending x=%0d y=%0d z=%0d", qx.size(), qy.size(), qz.size());
      qx.delete();
      qy.delete();
      qz.delete();
    end
  endtask

  task automatic go(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                    input logic [7:0] ed, input logic ebo, input logic eov);
    @(negedge clk);
    case (w)
      0: begin st_x = 1'b1; a_x = av; b_x = bv; i_x = bi; end
      1: begin st_y = 1'b1; a_y = av; b_y = bv; i_y = bi; end
      default: begin st_z = 1'b1; a_z = av[0]; b_z = bv[0]; i_z = bi; end
    endcase
    @(posedge clk);
    #1;
    push(w, '{ed, ebo, eov, ecount + (w == 0 ? 8 : w == 1 ? 2 : 1)});
    st_x = 1'b0;
    st_y = 1'b0;
    st_z = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] tt_d, tt_bo, tt_ov;
    tt_d  = 8'h96;
    tt_bo = 8'h8E;
    tt_ov = 8'h24;
    rst = 1'b1;
    {st_x, i_x, a_x, b_x} = '0;
    {st_y, i_y, a_y, b_y} = '0;
    {st_z, i_z, a_z, b_z} = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_v("reset_w8d1", {4'b0, busy_x, done_x, bo_x, ov_x, d_x}, 16'h0);
    expect_v("reset_w8d4", {4'b0, busy_y, done_y, bo_y, ov_y, d_y}, 16'h0);
    expect_v("reset_w1", {11'b0, busy_z, done_z, bo_z, ov_z, d_z}, 16'h0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      go(2, {7'b0, v[2]}, {7'b0, v[1]}, v[0], {7'b0, tt_d[i]}, tt_bo[i], tt_ov[i]);
    end

    @(negedge clk);
    st_x = 1'b1; a_x = 8'h05; b_x = 8'h03; i_x = 1'b0;
    @(posedge clk);
    #1;
    push(0, '{8'h02, 1'b0, 1'b0, ecount + 8});
    st_x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expect_v("busy_window", {14'b0, busy_x, done_x}, 16'h2);
    end
    wait_idle();
    go(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    go(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    go(0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    go(0, 8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0);

    go(1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
    go(1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    go(1, 8'h81, 8'h7F, 1'b0, 8'h02, 1'b0, 1'b1);

    @(negedge clk);
    st_x = 1'b1; a_x = 8'h5A; b_x = 8'h21; i_x = 1'b0;
    @(posedge clk);
    #1;
    push(0, '{8'h39, 1'b0, 1'b0, ecount + 8});
    st_x = 1'b0;
    repeat (3) @(negedge clk);
    st_x = 1'b1; a_x = 8'hAA; b_x = 8'h55; i_x = 1'b1;
    @(negedge clk);
    st_x = 1'b0; a_x = 8'h11; b_x = 8'h22;
    wait_idle();

    @(negedge clk);
    st_x = 1'b1; a_x = 8'h12; b_x = 8'h34; i_x = 1'b0;
    @(posedge clk);
    #1;
    push(0, '{8'hDE, 1'b1, 1'b0, ecount + 8});
    push(0, '{8'h7F, 1'b0, 1'b1, ecount + 17});
    a_x = 8'h90; b_x = 8'h10; i_x = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    st_x = 1'b0;
    wait_idle();

    @(negedge clk);
    st_x = 1'b1; a_x = 8'h77; b_x = 8'h11; i_x = 1'b0;
    @(posedge clk);
    #1;
    st_x = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_v("reset_midrun", {4'b0, busy_x, done_x, bo_x, ov_x, d_x}, 16'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_v("no_done_after_reset", {14'b0, busy_x, done_x}, 16'h0);
    end
    go(0, 8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
